// File: rtl/rf_path_sequencer.sv
// Break-before-make sequencer for the RF front-end switch/LNA/mixer pins.
// A mode change first quiesces (LNAs shut, mixer off), waits SETTLE_CYCLES,
// moves the path switches with LNAs still shut, waits LNA_DELAY, and then
// applies the full target pattern. Abort forces a restart towards low_power.
module rf_path_sequencer #(
  parameter int SETTLE_CYCLES = 64,
  parameter int LNA_DELAY     = 32,
  parameter int CNT_W         = 16
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_mode,
  output logic       o_req_ready,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err_illegal,
  output logic [2:0] o_cur_mode,
  output logic [7:0] o_rf_pins
);

  typedef enum logic [1:0] {IDLE, WAIT_OFF, WAIT_SW} state_e;

  localparam logic [7:0]       PINS_RST  = 8'h56;
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LNA_M1    = CNT_W'(LNA_DELAY - 1);

  // Full pin pattern for each legal mode; 6/7 never reach this (rejected at accept).
  function automatic logic [7:0] tgt_pins(input logic [2:0] m);
    case (m)
      3'd1:    tgt_pins = 8'h66;
      3'd2:    tgt_pins = 8'h9D;
      3'd3:    tgt_pins = 8'h5D;
      3'd4:    tgt_pins = 8'h6B;
      3'd5:    tgt_pins = 8'hAB;
      default: tgt_pins = 8'h56;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       target_q, target_d;
  logic [2:0]       cur_q, cur_d;
  logic [7:0]       pins_q, pins_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q;

  logic       idle, at_rest, acc;
  logic       abort_run, abort_noop, req_illegal, req_same, req_start;
  logic       start, off_end, sw_end;
  logic [7:0] tgt;

  assign idle        = (state_q == IDLE);
  assign o_req_ready = idle && !i_abort;
  assign acc         = i_req_valid && o_req_ready;
  assign at_rest     = (cur_q == 3'd0) && (pins_q == PINS_RST);

  // Abort in IDLE is a request for mode 0 unless already fully at rest.
  assign abort_run   = idle && i_abort && !at_rest;
  assign abort_noop  = idle && i_abort && at_rest;
  assign req_illegal = acc && (i_req_mode[2:1] == 2'b11);
  assign req_same    = acc && !req_illegal && (i_req_mode == cur_q);
  assign req_start   = acc && !req_illegal && (i_req_mode != cur_q);
  // Abort mid-sequence restarts from quiesce, so the settle window is honoured again.
  assign start       = abort_run || req_start || (!idle && i_abort);
  assign off_end     = (state_q == WAIT_OFF) && !i_abort && (cnt_q == '0);
  assign sw_end      = (state_q == WAIT_SW) && !i_abort && (cnt_q == '0);
  assign tgt         = tgt_pins(target_q);

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, wait counter and latched target.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (start) begin
      state_d  = WAIT_OFF;
      cnt_d    = SETTLE_M1;
      target_d = i_abort ? 3'd0 : i_req_mode;
    end else if (off_end) begin
      state_d = WAIT_SW;
      cnt_d   = LNA_M1;
    end else if (sw_end) begin
      state_d = IDLE;
    end else if (!idle) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pin pattern, completed mode and status pulses.
  always_comb begin
    pins_d = pins_q;
    cur_d  = cur_q;
    if (start)        pins_d = {pins_q[7:3], 3'b110};
    else if (off_end) pins_d = {tgt[7:3], 3'b110};
    else if (sw_end) begin
      pins_d = tgt;
      cur_d  = target_q;
    end
    done_d = req_same || abort_noop || sw_end;
    err_d  = req_illegal;
  end

  // Datapath and output registers.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      cnt_q    <= '0;
      target_q <= 3'd0;
      cur_q    <= 3'd0;
      pins_q   <= PINS_RST;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      pins_q   <= pins_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err_illegal = err_q;
  assign o_cur_mode    = cur_q;
  assign o_rf_pins     = pins_q;

endmodule

// File: tb/tb_rf_path_sequencer.sv
// Bench for rf_path_sequencer: done/err pulses are scoreboarded, pin timeline
// is compared cycle by cycle against a small break-before-make model.
module tb_rf_path_sequencer;
  localparam int S = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_mode = 3'd0;
  logic       abort = 1'b0;
  logic       req_ready, busy, done, err;
  logic [2:0] cur_mode;
  logic [7:0] pins;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       err;
    logic [2:0] cur;
    logic [7:0] pins;
  } exp_t;
  exp_t sb[$];

  logic [7:0] tgt_tbl [8] = '{8'h56, 8'h66, 8'h9D, 8'h5D, 8'h6B, 8'hAB, 8'h56, 8'h56};

  rf_path_sequencer #(.SETTLE_CYCLES(S), .LNA_DELAY(L), .CNT_W(8)) dut (
    .i_sys_clk(clk), .i_rst_b(rst_b), .i_req_valid(req_valid), .i_req_mode(req_mode),
    .o_req_ready(req_ready), .i_abort(abort), .o_busy(busy), .o_done(done),
    .o_err_illegal(err), .o_cur_mode(cur_mode), .o_rf_pins(pins));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected pins k edges after the sequence start edge.
  function automatic logic [7:0] exp_pins(input logic [7:0] from, input logic [2:0] to, input int k);
    logic [7:0] t;
    t = tgt_tbl[to];
    if (k < S)          return {from[7:3], 3'b110};
    else if (k < S + L) return {t[7:3], 3'b110};
    else                return t;
  endfunction

  // Scoreboard: every done/err pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_b && (done || err)) begin
      if (sb.size() == 0) chk("sb_unexp", {30'd0, done, err}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_err", err, e.err);
        chk("sb_done", done, !e.err);
        chk("sb_cur", cur_mode, e.cur);
        chk("sb_pins", pins, e.pins);
      end
    end
  end

  task automatic push(input logic e, input logic [2:0] c, input logic [7:0] p);
    exp_t x;
    x.err = e; x.cur = c; x.pins = p;
    sb.push_back(x);
  endtask

  // Drive one request at a negedge; returns at the negedge after the accept edge.
  task automatic req(input logic [2:0] m);
    req_valid = 1'b1;
    req_mode  = m;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Walk a whole sequence from k=0 (negedge after start edge) to completion.
  task automatic run_seq(input logic [7:0] from, input logic [2:0] to, input logic [2:0] old_cur);
    for (int k = 0; k <= S + L; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("pins_k%0d", k), pins, exp_pins(from, to, k));
      chk($sformatf("busy_k%0d", k), busy, (k < S + L) ? 1 : 0);
      chk($sformatf("cur_k%0d", k), cur_mode, (k < S + L) ? old_cur : to);
    end
    chk("ready_after", req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pins", pins, 8'h56);
    chk("rst_cur", cur_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);

    // Abort while already at rest: done pulse only.
    push(1'b0, 3'd0, 8'h56);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_noop_busy", busy, 0);
    @(negedge clk);

    // 0 -> 2, 2 -> 4.
    push(1'b0, 3'd2, 8'h9D);
    req(3'd2);
    run_seq(8'h56, 3'd2, 3'd0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    push(1'b0, 3'd4, 8'h6B);
    req(3'd4);
    run_seq(8'h9D, 3'd4, 3'd2);
    @(negedge clk);

    // Same mode and illegal mode.
    push(1'b0, 3'd4, 8'h6B);
    req(3'd4);
    chk("same_busy", busy, 0);
    @(negedge clk);
    chk("same_pulse_end", done, 0);
    push(1'b1, 3'd4, 8'h6B);
    req(3'd7);
    chk("ill_busy", busy, 0);
    chk("ill_pins", pins, 8'h6B);
    @(negedge clk);
    chk("ill_pulse_end", err, 0);

    // 4 -> 5 aborted in WAIT_SW.
    push(1'b0, 3'd0, 8'h56);
    req(3'd5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("ab_pins_k%0d", k), pins, exp_pins(8'h6B, 3'd5, k));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    run_seq(8'hAE, 3'd0, 3'd4);
    @(negedge clk);

    // Go to mode 1, then abort with a request held.
    push(1'b0, 3'd1, 8'h66);
    req(3'd1);
    run_seq(8'h56, 3'd1, 3'd0);
    @(negedge clk);
    abort = 1'b1;
    req_valid = 1'b1;
    req_mode = 3'd3;
    #1;
    chk("abort_ready", req_ready, 0);
    push(1'b0, 3'd0, 8'h56);
    push(1'b0, 3'd3, 8'h5D);
    @(negedge clk);
    abort = 1'b0;
    run_seq(8'h66, 3'd0, 3'd1);
    @(negedge clk);
    req_valid = 1'b0;
    run_seq(8'h56, 3'd3, 3'd0);
    @(negedge clk);

    // Reset mid-sequence discards the partial sequence.
    push(1'b0, 3'd1, 8'h66);
    req(3'd1);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("midrst_pins", pins, 8'h56);
    chk("midrst_cur", cur_mode, 0);
    chk("midrst_busy", busy, 0);
    sb.delete();
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
